snd_capture: RTL

//  Serial-to-parallel capture for the sound interface: the receive-side counterpart of the BGM

---
 rtl/snd_capture.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/snd_capture.sv
// ============================================================================
// snd_capture
// ----------------------------------------------------------------------------
// Receive side of the sound interface. Takes the serial ADC stream and turns
// each 64-slot frame into one 32-bit word for the record FIFO. The frame
// position comes from the shared slot counter serial_cnt. The low sample fills
// slots LO_START..LO_START+15 and the high sample fills slots
// HI_START..HI_START+15, MSB first. All other slots are padding.
//
// Recording starts in ARM and waits for a frame boundary. This makes the
// first word written a whole frame and not the tail of a frame that was
// already in progress.
//
// Optional build macro:
//   SND_REC_PEAK_EN  adds PEAK_LO / PEAK_HI. These hold the peak magnitude of
//                    each channel over every frame completed while
//                    recording.
//
// Ports:
//   SND_MCLK      in   1   master sound clock, rising edge
//   SND_RST       in   1   asynchronous reset, active-high
//   serial_cnt    in   6   frame slot counter 0..63
//   SND_DIN       in   1   serial ADC data, stable for the whole slot
//   M_REC_ENABLE  in   1   record enable
//   FIFO_FULL     in   1   record FIFO full
//   FIFO_WR       out  1   one-cycle FIFO write strobe
//   FIFO_DIN      out  32  {high sample, low sample}, held until next write
//   REC_OVERRUN   out  1   sticky: a completed frame was dropped (FIFO full)
//   PEAK_LO       out  15  (SND_REC_PEAK_EN only) low channel peak |sample|
//   PEAK_HI       out  15  (SND_REC_PEAK_EN only) high channel peak |sample|
// ============================================================================
module snd_capture #(
    parameter int SAMPLE_W = 16,
    parameter int LO_START = 1,
    parameter int HI_START = 33
) (
    input  logic                  SND_MCLK,
    input  logic                  SND_RST,
    input  logic [5:0]            serial_cnt,
    input  logic                  SND_DIN,
    input  logic                  M_REC_ENABLE,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WR,
    output logic [2*SAMPLE_W-1:0] FIFO_DIN,
    output logic                  REC_OVERRUN
`ifdef SND_REC_PEAK_EN
    ,
    output logic [SAMPLE_W-2:0]   PEAK_LO,
    output logic [SAMPLE_W-2:0]   PEAK_HI
`endif
);

    localparam logic [5:0] LO_FIRST = 6'(LO_START);
    localparam logic [5:0] LO_LAST  = 6'(LO_START + SAMPLE_W - 1);
    localparam logic [5:0] HI_FIRST = 6'(HI_START);
    localparam logic [5:0] HI_LAST  = 6'(HI_START + SAMPLE_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              old_cnt_q, old_cnt_d;
    logic                    en_q, en_d;
    logic [SAMPLE_W-1:0]     lo_sr_q, lo_sr_d;
    logic [SAMPLE_W-1:0]     hi_sr_q, hi_sr_d;
    logic                    fifo_wr_q, fifo_wr_d;
    logic [2*SAMPLE_W-1:0]   fifo_din_q, fifo_din_d;
    logic                    overrun_q, overrun_d;

    logic slot_strobe;
    logic frame_end;
    logic in_lo;
    logic in_hi;
    logic frame_done;

    // Slot decode. A slot change is seen when the counter value differs
    // from the previous cycle. A jump of more than one is still a normal
    // slot, so a glitched frame is written as it stands.
    always_comb begin
        slot_strobe = (serial_cnt != old_cnt_q);
        frame_end   = (old_cnt_q == 6'o77) && (serial_cnt == 6'o00);
        in_lo       = (serial_cnt >= LO_FIRST) && (serial_cnt <= LO_LAST);
        in_hi       = (serial_cnt >= HI_FIRST) && (serial_cnt <= HI_LAST);
        // A completed frame only counts while recording is still enabled.
        // This drops a frame_end that coincides with enable falling.
        frame_done  = (state_q == CAPTURE) && frame_end && M_REC_ENABLE;
    end

    // State register.
    always_ff @(posedge SND_MCLK or posedge SND_RST) begin
        if (SND_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Dropping the enable returns to IDLE from any
    // state, so every new recording goes through ARM again.
    always_comb begin
        state_d = state_q;
        if (!M_REC_ENABLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (frame_end) state_d = CAPTURE;
                CAPTURE: state_d = CAPTURE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output and datapath logic. The shift registers sample SND_DIN once
    // per slot, on the cycle the slot changes. The finished word is
    // registered, so it reaches the FIFO one cycle after frame_end.
    always_comb begin
        old_cnt_d  = serial_cnt;
        en_d       = M_REC_ENABLE;
        lo_sr_d    = lo_sr_q;
        hi_sr_d    = hi_sr_q;
        fifo_wr_d  = frame_done && !FIFO_FULL;
        fifo_din_d = fifo_din_q;
        overrun_d  = overrun_q;

        if (!M_REC_ENABLE) begin
            lo_sr_d = '0;
            hi_sr_d = '0;
        end else if (slot_strobe) begin
            if (in_lo) lo_sr_d = {lo_sr_q[SAMPLE_W-2:0], SND_DIN};
            if (in_hi) hi_sr_d = {hi_sr_q[SAMPLE_W-2:0], SND_DIN};
        end

        if (fifo_wr_d) begin
            fifo_din_d = {hi_sr_q, lo_sr_q};
        end

        // Clear on the falling edge of enable, but a set in the same
        // cycle wins.
        if (en_q && !M_REC_ENABLE) overrun_d = 1'b0;
        if (frame_done && FIFO_FULL) overrun_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge SND_MCLK or posedge SND_RST) begin
        if (SND_RST) begin
            old_cnt_q  <= 6'o00;
            en_q       <= 1'b0;
            lo_sr_q    <= '0;
            hi_sr_q    <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            old_cnt_q  <= old_cnt_d;
            en_q       <= en_d;
            lo_sr_q    <= lo_sr_d;
            hi_sr_q    <= hi_sr_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_din_q <= fifo_din_d;
            overrun_q  <= overrun_d;
        end
    end

    assign FIFO_WR     = fifo_wr_q;
    assign FIFO_DIN    = fifo_din_q;
    assign REC_OVERRUN = overrun_q;

`ifdef SND_REC_PEAK_EN
    logic [SAMPLE_W-2:0] peak_lo_q, peak_lo_d;
    logic [SAMPLE_W-2:0] peak_hi_q, peak_hi_d;
    logic [SAMPLE_W-2:0] mag_lo;
    logic [SAMPLE_W-2:0] mag_hi;

    // Magnitude of a two's complement sample. The most negative value
    // has no positive counterpart, so it saturates to all ones.
    function automatic logic [SAMPLE_W-2:0] abs_mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] neg;
        neg = -s;
        if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            return {(SAMPLE_W-1){1'b1}};
        end else if (s[SAMPLE_W-1]) begin
            return neg[SAMPLE_W-2:0];
        end else begin
            return s[SAMPLE_W-2:0];
        end
    endfunction

    // The peaks follow every completed frame, including frames dropped
    // because the FIFO was full.
    always_comb begin
        mag_lo    = abs_mag(lo_sr_q);
        mag_hi    = abs_mag(hi_sr_q);
        peak_lo_d = peak_lo_q;
        peak_hi_d = peak_hi_q;
        if (!M_REC_ENABLE) begin
            peak_lo_d = '0;
            peak_hi_d = '0;
        end else if (frame_done) begin
            if (mag_lo > peak_lo_q) peak_lo_d = mag_lo;
            if (mag_hi > peak_hi_q) peak_hi_d = mag_hi;
        end
    end

    // Peak registers.
    always_ff @(posedge SND_MCLK or posedge SND_RST) begin
        if (SND_RST) begin
            peak_lo_q <= '0;
            peak_hi_q <= '0;
        end else begin
            peak_lo_q <= peak_lo_d;
            peak_hi_q <= peak_hi_d;
        end
    end

    assign PEAK_LO = peak_lo_q;
    assign PEAK_HI = peak_hi_q;
`endif

endmodule
